// File: rtl/rmt_pkg.sv
// ---------------------------------------------------------------------------
// rmt_pkg
// Shared constants for the RMT ingress arbiter slice:
//   - default AXI4-Stream widths (tdata 256, tuser 128)
//   - FIFO entry width helper: {tdata, tuser, tkeep, tlast}
//   - arbiter state encoding
// ---------------------------------------------------------------------------
package rmt_pkg;

  localparam int AXIS_DATA_W  = 256;
  localparam int AXIS_TUSER_W = 128;

  // One buffered beat: data + metadata + byte enables + end-of-packet flag.
  function automatic int entry_width(input int data_w, input int tuser_w);
    return data_w + tuser_w + (data_w / 8) + 1;
  endfunction

  localparam int AXIS_ENTRY_W = entry_width(AXIS_DATA_W, AXIS_TUSER_W);

  // Arbiter state encoding.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// ---------------------------------------------------------------------------
// fallthrough_small_fifo
// Small synchronous FIFO whose head entry is visible on dout whenever
// empty is low (no read latency). Occupancy is registered, so a write in
// cycle t clears empty in cycle t+1.
//
// Ports:
//   clk, aresetn   clock, asynchronous active-low reset (flushes the FIFO)
//   din, wr_en     write data / write strobe (ignored when full)
//   rd_en          pop the head entry (ignored when empty)
//   dout           current head entry
//   empty          no entries stored
//   nearly_full    one slot or fewer left; used as upstream back-pressure
// ---------------------------------------------------------------------------
module fallthrough_small_fifo #(
  parameter int WIDTH          = 417,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_LEVEL = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_LEVEL   = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      wr_ok;
  logic                      rd_ok;

  assign wr_ok = wr_en && (count != FULL_LEVEL);
  assign rd_ok = rd_en && (count != '0);

  // Storage is not reset: the empty flag gates every use of its contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous write and read leaves occupancy unchanged.
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (!wr_ok && rd_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  assign dout        = mem[rd_ptr];
  assign empty       = (count == '0);
  assign nearly_full = (count >= NF_LEVEL);

endmodule

// File: rtl/rmt_input_arbiter.sv
// ---------------------------------------------------------------------------
// rmt_input_arbiter
// Packet-level round-robin merge of NUM_PORTS (2..8) AXI4-Stream ingress
// ports into one stream feeding the RMT packet filter. Each port is
// buffered in its own fallthrough FIFO; a granted port owns the output
// until its tlast beat is accepted, so packets never interleave.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// valid never depends on ready; ingress ready depends only on that port's
// FIFO occupancy; the output beat holds stable while valid && !ready.
//
// Ports:
//   clk, aresetn                        clock, async active-low reset
//   s_axis_tdata/tkeep/tuser/tlast      per-port ingress beat (slice i = port i)
//   s_axis_tvalid / s_axis_tready       per-port handshake
//   m_axis_tdata/tkeep/tuser/tlast      merged egress beat (zero when !tvalid)
//   m_axis_tvalid / m_axis_tready       egress handshake
//   dbg_state, dbg_grant                arbiter state and current grant
// ---------------------------------------------------------------------------
module rmt_input_arbiter
  import rmt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = AXIS_DATA_W,
  parameter int C_S_AXIS_TUSER_WIDTH = AXIS_TUSER_W,
  parameter int NUM_PORTS            = 4,
  parameter int FIFO_DEPTH_BITS      = 4
) (
  input  logic                                          clk,
  input  logic                                          aresetn,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                          s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                          s_axis_tready,
  input  logic [NUM_PORTS-1:0]                          s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic                                          m_axis_tlast,
  output logic                                          dbg_state,
  output logic [2:0]                                    dbg_grant
);

  localparam int DW      = C_S_AXIS_DATA_WIDTH;
  localparam int UW      = C_S_AXIS_TUSER_WIDTH;
  localparam int KW      = C_S_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_W = entry_width(DW, UW);
  localparam int GW      = $clog2(NUM_PORTS);

  logic                 state;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        last_grant;

  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] fifo_nearly_full;
  logic [NUM_PORTS-1:0] fifo_wr;
  logic [NUM_PORTS-1:0] fifo_rd;
  logic [ENTRY_W-1:0]   fifo_head [NUM_PORTS];

  logic [ENTRY_W-1:0]   sel_head;
  logic                 head_last;
  logic                 out_fire;
  logic [GW-1:0]        next_grant;

  // Round-robin pick: rotate the request vector so the port after
  // last_grant sits at bit 0, priority-encode, then undo the rotation.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [GW-1:0]        last);
    logic [NUM_PORTS-1:0] rot;
    int                   start;
    int                   offs;
    logic                 found;
    start = (int'(last) + 1) % NUM_PORTS;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rot[i] = req[(start + i) % NUM_PORTS];
    end
    offs  = 0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && rot[i]) begin
        offs  = i;
        found = 1'b1;
      end
    end
    return GW'((start + offs) % NUM_PORTS);
  endfunction

  // Per-port buffering. Ingress ready is purely local to each FIFO.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign s_axis_tready[i] = !fifo_nearly_full[i];
    assign fifo_wr[i]       = s_axis_tvalid[i] && s_axis_tready[i];
    assign fifo_rd[i]       = out_fire && (grant == GW'(i));

    fallthrough_small_fifo #(
      .WIDTH          (ENTRY_W),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk         (clk),
      .aresetn     (aresetn),
      .din         ({s_axis_tdata[i*DW +: DW],
                     s_axis_tuser[i*UW +: UW],
                     s_axis_tkeep[i*KW +: KW],
                     s_axis_tlast[i]}),
      .wr_en       (fifo_wr[i]),
      .rd_en       (fifo_rd[i]),
      .dout        (fifo_head[i]),
      .empty       (fifo_empty[i]),
      .nearly_full (fifo_nearly_full[i])
    );
  end

  assign sel_head      = fifo_head[grant];
  assign head_last     = sel_head[0];
  assign m_axis_tvalid = (state == ST_BURST) && !fifo_empty[grant];
  assign out_fire      = m_axis_tvalid && m_axis_tready;
  assign next_grant    = rr_pick(~fifo_empty, last_grant);

  // Egress fields are forced to zero whenever no beat is offered, so stale
  // FIFO storage never shows on the bus (including right after reset).
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tuser = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    if (m_axis_tvalid) begin
      {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast} = sel_head;
    end
  end

  // IDLE picks the next port; BURST holds the grant until tlast is accepted.
  // An empty granted FIFO mid-packet just drops valid; the grant stays.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
    end else if (state == ST_IDLE) begin
      if (|(~fifo_empty)) begin
        grant      <= next_grant;
        last_grant <= next_grant;
        state      <= ST_BURST;
      end
    end else begin
      if (out_fire && head_last) begin
        state <= ST_IDLE;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_grant = 3'(grant);

endmodule

// File: tb/tb_rmt_input_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rmt_input_arbiter
// Directed bench for rmt_input_arbiter (4 ports, 16-deep FIFOs).
// Every beat carries a 32-bit tag {port, packet, beat, 8'h5A} replicated
// across tdata/tuser and used directly as tkeep. Each test pushes its
// hand-ordered expected beats into exp_q; a negedge monitor pops and
// compares every accepted output beat and records its accept cycle.
// ---------------------------------------------------------------------------
module tb_rmt_input_arbiter;
  import rmt_pkg::*;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic aresetn;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP*KW-1:0] s_axis_tkeep;
  logic [NP*UW-1:0] s_axis_tuser;
  logic [NP-1:0]    s_axis_tvalid;
  logic [NP-1:0]    s_axis_tready;
  logic [NP-1:0]    s_axis_tlast;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic [UW-1:0]    m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic             dbg_state;
  logic [2:0]       dbg_grant;

  logic [31:0] drv_word  [NP];
  logic        drv_valid [NP];
  logic        drv_last  [NP];

  always_comb begin
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    for (int i = 0; i < NP; i++) begin
      s_axis_tdata[i*DW +: DW] = {8{drv_word[i]}};
      s_axis_tuser[i*UW +: UW] = {4{drv_word[i]}};
      s_axis_tkeep[i*KW +: KW] = drv_word[i];
      s_axis_tvalid[i]         = drv_valid[i];
      s_axis_tlast[i]          = drv_last[i];
    end
  end

  rmt_input_arbiter #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .NUM_PORTS            (NP),
    .FIFO_DEPTH_BITS      (4)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .dbg_state     (dbg_state),
    .dbg_grant     (dbg_grant)
  );

  // ---------------- checking ----------------
  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int p, input int pkt, input int b);
    return {8'(p), 8'(pkt), 8'(b), 8'h5A};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [32:0] exp_q[$];
  int          acc_q[$];
  logic [32:0] mon_e;

  always @(negedge clk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      acc_q.push_back(cyc + 1);
      check_eq("beat_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("out_tdata", m_axis_tdata, {8{mon_e[31:0]}});
        check_eq("out_tuser", 256'(m_axis_tuser), 256'({4{mon_e[31:0]}}));
        check_eq("out_tkeep", 256'(m_axis_tkeep), 256'(mon_e[31:0]));
        check_eq("out_tlast", 256'(m_axis_tlast), 256'(mon_e[32]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input int pkt, input int b, input logic last);
    drv_valid[p] = 1'b1;
    drv_word[p]  = mk(p, pkt, b);
    drv_last[p]  = last;
  endtask

  task automatic idle(input int p);
    drv_valid[p] = 1'b0;
    drv_last[p]  = 1'b0;
    drv_word[p]  = '0;
  endtask

  task automatic exp_push(input int p, input int pkt, input int b, input logic last);
    exp_q.push_back({last, mk(p, pkt, b)});
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NP; i++) idle(i);
    m_axis_tready = 1'b1;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic check_gaps(input string tag, input int exp_n, input int g [8]);
    check_eq({tag, "_count"}, 256'(acc_q.size()), 256'(exp_n));
    if (acc_q.size() == exp_n) begin
      for (int i = 0; i < exp_n - 1; i++) begin
        check_eq($sformatf("%s_gap%0d", tag, i), 256'(acc_q[i+1] - acc_q[i]), 256'(g[i]));
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int   w0;
  int   k;
  int   n;
  logic rdy;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    aresetn       = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < NP; i++) idle(i);

    // Reset state
    do_reset();
    check_eq("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    check_eq("rst_tlast",  256'(m_axis_tlast),  256'(0));
    check_eq("rst_tdata",  m_axis_tdata,        256'(0));
    check_eq("rst_tkeep",  256'(m_axis_tkeep),  256'(0));
    check_eq("rst_tuser",  256'(m_axis_tuser),  256'(0));
    check_eq("rst_sready", 256'(s_axis_tready), 256'(4'hF));
    check_eq("rst_state",  256'(dbg_state),     256'(ST_IDLE));

    // A: 3-beat packet on port 2, valid 2 cycles after first write
    exp_push(2, 1, 0, 1'b0);
    exp_push(2, 1, 1, 1'b0);
    exp_push(2, 1, 2, 1'b1);
    put(2, 1, 0, 1'b0);
    tick();
    w0 = cyc;
    check_eq("a_lat_t1", 256'(m_axis_tvalid), 256'(0));
    put(2, 1, 1, 1'b0);
    tick();
    check_eq("a_lat_t2", 256'(m_axis_tvalid), 256'(1));
    put(2, 1, 2, 1'b1);
    tick();
    idle(2);
    wait_drain("a_drain");
    tick();
    check_eq("a_end_valid", 256'(m_axis_tvalid), 256'(0));
    check_eq("a_end_state", 256'(dbg_state), 256'(ST_IDLE));
    if (acc_q.size() == 3) check_eq("a_first_lat", 256'(acc_q[0] - w0), 256'(2));
    check_gaps("a", 3, '{1, 1, 0, 0, 0, 0, 0, 0});

    // B: ports 0..3 each with a 2-beat packet at once -> 0,1,2,3
    do_reset();
    for (int p = 0; p < NP; p++) begin
      exp_push(p, 2, 0, 1'b0);
      exp_push(p, 2, 1, 1'b1);
    end
    for (int p = 0; p < NP; p++) put(p, 2, 0, 1'b0);
    tick();
    for (int p = 0; p < NP; p++) put(p, 2, 1, 1'b1);
    tick();
    for (int p = 0; p < NP; p++) idle(p);
    wait_drain("b_drain");
    check_gaps("b", 8, '{1, 2, 1, 2, 1, 2, 1, 0});

    // C: port 1 stalls mid-packet while port 3 waits
    do_reset();
    for (int b = 0; b < 4; b++) exp_push(1, 3, b, b == 3);
    exp_push(3, 3, 0, 1'b0);
    exp_push(3, 3, 1, 1'b1);
    put(1, 3, 0, 1'b0);
    put(3, 3, 0, 1'b0);
    tick();
    idle(1);
    put(3, 3, 1, 1'b1);
    tick();
    idle(3);
    tick();
    tick();
    check_eq("c_stall_valid", 256'(m_axis_tvalid), 256'(0));
    check_eq("c_stall_state", 256'(dbg_state), 256'(ST_BURST));
    check_eq("c_stall_grant", 256'(dbg_grant), 256'(1));
    tick();
    tick();
    for (int b = 1; b < 4; b++) begin
      put(1, 3, b, b == 3);
      tick();
    end
    idle(1);
    wait_drain("c_drain");
    check_gaps("c", 6, '{5, 1, 1, 2, 1, 0, 0, 0});

    // D: downstream stalls 20 cycles while port 0 streams a 20-beat packet
    do_reset();
    for (int b = 0; b < 20; b++) exp_push(0, 4, b, b == 19);
    m_axis_tready = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      put(0, 4, k, k == 19);
      if (i == 5 || i == 19) begin
        check_eq("d_hold_valid", 256'(m_axis_tvalid), 256'(1));
        check_eq("d_hold_tdata", m_axis_tdata, {8{mk(0, 4, 0)}});
      end
      rdy = s_axis_tready[0];
      tick();
      if (rdy) k++;
    end
    check_eq("d_accepted_while_stalled", 256'(k), 256'(15));
    check_eq("d_sready_low", 256'(s_axis_tready[0]), 256'(0));
    check_eq("d_other_ready", 256'(s_axis_tready[3:1]), 256'(3'b111));
    m_axis_tready = 1'b1;
    n = 0;
    while (k < 20 && n < 100) begin
      put(0, 4, k, k == 19);
      rdy = s_axis_tready[0];
      tick();
      if (rdy) k++;
      n++;
    end
    idle(0);
    check_eq("d_all_sent", 256'(k), 256'(20));
    wait_drain("d_drain");
    check_eq("d_out_count", 256'(acc_q.size()), 256'(20));

    // E: asynchronous reset in the middle of a port 1 packet
    do_reset();
    exp_push(1, 5, 0, 1'b0);
    put(1, 5, 0, 1'b0);
    tick();
    put(1, 5, 1, 1'b0);
    tick();
    idle(1);
    tick();
    check_eq("e_pre_valid", 256'(m_axis_tvalid), 256'(1));
    check_eq("e_pre_drain", 256'(exp_q.size()), 256'(0));
    aresetn = 1'b0;
    #1;
    check_eq("e_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    check_eq("e_rst_tdata",  m_axis_tdata,        256'(0));
    check_eq("e_rst_tlast",  256'(m_axis_tlast),  256'(0));
    check_eq("e_rst_state",  256'(dbg_state),     256'(ST_IDLE));
    check_eq("e_rst_empty",  256'(dut.fifo_empty), 256'(4'hF));
    tick();
    aresetn = 1'b1;
    tick();
    exp_q.delete();
    acc_q.delete();
    for (int b = 0; b < 3; b++) exp_push(0, 6, b, b == 2);
    for (int b = 0; b < 3; b++) begin
      put(0, 6, b, b == 2);
      tick();
    end
    idle(0);
    wait_drain("e_drain");
    check_eq("e_out_count", 256'(acc_q.size()), 256'(3));

    // F: port 2 streams 1-beat packets, port 0 sends one 2-beat packet
    do_reset();
    exp_push(2, 0, 0, 1'b1);
    exp_push(0, 7, 0, 1'b0);
    exp_push(0, 7, 1, 1'b1);
    for (int q = 1; q < 8; q++) exp_push(2, q, 0, 1'b1);
    for (int q = 0; q < 8; q++) begin
      put(2, q, 0, 1'b1);
      if (q == 1) put(0, 7, 0, 1'b0);
      if (q == 2) put(0, 7, 1, 1'b1);
      if (q == 3) idle(0);
      tick();
    end
    idle(2);
    idle(0);
    wait_drain("f_drain");
    check_eq("f_out_count", 256'(acc_q.size()), 256'(10));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
